// File: rtl/osc_sequencer_pkg.sv
// Shared types and widths for the oscillator sequencer and its period meter.
package osc_seq_pkg;

  localparam int K_W    = 4;
  localparam int BC_W   = 17;
  localparam int WAVE_W = 12;
  localparam int CNT_W  = 16;
  localparam int AMP_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/osc_sequencer_if.sv
// Request/acknowledge channel between top-level control and the oscillator sequencer.
interface osc_sequencer_if;
  import osc_seq_pkg::*;

  logic             req;
  logic [K_W-1:0]   reqK;
  logic [AMP_W-1:0] reqAmp;
  logic             stop;
  logic             ack;
  logic             err;

  modport master (output req, reqK, reqAmp, stop, input ack, err);
  modport slave  (input req, reqK, reqAmp, stop, output ack, err);

endinterface

// File: rtl/osc_sequencer_period_meter.sv
// Rising-zero-crossing period meter with a saturating cycle counter and watchdog compare.
module osc_period_meter
  import osc_seq_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [WAVE_W-1:0] wave,
  output logic [CNT_W-1:0]         periodCycles,
  output logic                     periodValid,
  output logic                     timeout
);

  logic [CNT_W-1:0] cnt_p0;
  logic             sign_p0;
  logic             sign_vld_p0;
  logic             seen_p0;
  logic             rise;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= TIMEOUT) ? TIMEOUT : v + 1'b1;
  endfunction

  // Negative sample followed by a non-negative one; needs a valid previous sample.
  assign rise    = sign_vld_p0 && sign_p0 && !wave[WAVE_W-1];
  assign timeout = en && (cnt_p0 == TIMEOUT);

  always_ff @(posedge clk_in) begin
    if (en) sign_p0 <= wave[WAVE_W-1];
  end

  // Stage p0: sign history, counter and published period
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_p0       <= '0;
      sign_vld_p0  <= 1'b0;
      seen_p0      <= 1'b0;
      periodCycles <= '0;
      periodValid  <= 1'b0;
    end else if (clear) begin
      cnt_p0      <= '0;
      sign_vld_p0 <= 1'b0;
      seen_p0     <= 1'b0;
      periodValid <= 1'b0;
    end else begin
      periodValid <= 1'b0;
      if (en) begin
        sign_vld_p0 <= 1'b1;
        if (rise) begin
          if (seen_p0) begin
            periodCycles <= cnt_p0;
            periodValid  <= 1'b1;
          end
          seen_p0 <= 1'b1;
          cnt_p0  <= 16'd1;
        end else begin
          cnt_p0 <= sat_inc(cnt_p0);
        end
      end
    end
  end

endmodule

// File: rtl/osc_sequencer.sv
// Oscillator controller: validates config requests, loads/retunes the oscillator and reloads it on stall.
module osc_sequencer
  import osc_seq_pkg::*;
#(
  parameter int unsigned      LOAD_CYCLES = 2,
  parameter logic [K_W-1:0]   K_MIN       = 4'd1,
  parameter logic [AMP_W-1:0] AMP_MAX     = 16'h7FFF,
  parameter logic [CNT_W-1:0] TIMEOUT     = 16'hFFFF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  osc_sequencer_if.slave           ctl,
  output logic [K_W-1:0]           oscK,
  output logic                     oscLoad,
  output logic [BC_W-1:0]          oscBc,
  input  logic signed [WAVE_W-1:0] wave,
  output logic                     running,
  output logic [CNT_W-1:0]         periodCycles,
  output logic                     periodValid,
  output logic                     stall
);

  localparam logic [3:0] LOAD_LAST = 4'(LOAD_CYCLES - 1);

  state_t           state, state_d;
  logic [3:0]       load_cnt, load_cnt_d;
  logic [K_W-1:0]   cfg_k, k_d;
  logic [AMP_W-1:0] cfg_amp, amp_d;
  logic             ack_d, err_d, stall_d;
  logic             req_ok;
  logic             timeout;

  function automatic logic [AMP_W-1:0] clamp_amp(input logic [AMP_W-1:0] amp);
    return (amp > AMP_MAX) ? AMP_MAX : amp;
  endfunction

  assign req_ok = (ctl.reqK >= K_MIN) && (ctl.reqAmp != '0);

  always_comb begin
    state_d    = state;
    load_cnt_d = load_cnt;
    k_d        = cfg_k;
    amp_d      = cfg_amp;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    stall_d    = 1'b0;
    if (ctl.stop) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (ctl.req) begin
            if (req_ok) begin
              ack_d      = 1'b1;
              k_d        = ctl.reqK;
              amp_d      = clamp_amp(ctl.reqAmp);
              state_d    = LOAD;
              load_cnt_d = '0;
            end else begin
              err_d = 1'b1;
            end
          end else if (timeout) begin
            // Reload with the config already latched
            stall_d    = 1'b1;
            state_d    = LOAD;
            load_cnt_d = '0;
          end
        end
        LOAD: begin
          if (load_cnt == LOAD_LAST) state_d = RUN;
          else load_cnt_d = load_cnt + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      load_cnt <= '0;
      cfg_k    <= K_MIN;
      cfg_amp  <= '0;
      ctl.ack  <= 1'b0;
      ctl.err  <= 1'b0;
      stall    <= 1'b0;
    end else begin
      state    <= state_d;
      load_cnt <= load_cnt_d;
      cfg_k    <= k_d;
      cfg_amp  <= amp_d;
      ctl.ack  <= ack_d;
      ctl.err  <= err_d;
      stall    <= stall_d;
    end
  end

  assign oscK    = cfg_k;
  assign oscLoad = (state != RUN);
  assign oscBc   = (state == IDLE) ? '0 : {1'b0, cfg_amp};
  assign running = (state == RUN);

  // Clearing on the next state keeps a crossing in the last RUN cycle from publishing during LOAD.
  osc_period_meter #(
    .TIMEOUT(TIMEOUT)
  ) u_meter (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clear       (state_d != RUN),
    .en          (state == RUN),
    .wave        (wave),
    .periodCycles(periodCycles),
    .periodValid (periodValid),
    .timeout     (timeout)
  );

endmodule

// File: doc/osc_sequencer.md
Name: osc_sequencer

Overview:
- Controller for the sinusoidal oscillator datapath.
- Accepts frequency (k) and amplitude requests over a req/ack handshake, checks them, then drives the oscillator's k, loadBoundaryCondition and boundaryCondition inputs to start, retune or silence it.
- Monitors the oscillator's 12-bit wave output. Measures the period in clock cycles from rising zero crossings, and reloads the oscillator automatically when it stalls.
- Sits between the top-level control and one oscillator instance.

Parameters:
- LOAD_CYCLES, 2: cycles loadBoundaryCondition is held high per load (1..15).
- K_MIN, 1: smallest accepted k; smaller values are rejected.
- AMP_MAX, 16'h7FFF: amplitude clamp ceiling.
- TIMEOUT, 16'hFFFF: cycles without a rising crossing before a stall is declared.

Ports:
- clk_in  in  1  system clock; all logic on rising edge.
- rst_in  in  1  synchronous, active-high reset.
- req  in  1  configuration request; held high by the requester until ack or err.
- reqK  in  4  requested k.
- reqAmp  in  16  requested amplitude (unsigned).
- stop  in  1  level; while high, returns to and stays in IDLE.
- ack  out  1  one-cycle pulse: request accepted.
- err  out  1  one-cycle pulse: request rejected.
- oscK  out  4  to oscillator k.
- oscLoad  out  1  to oscillator loadBoundaryCondition.
- oscBc  out  17  to oscillator boundaryCondition.
- wave  in  12  from oscillator; two's complement.
- running  out  1  high in RUN.
- periodCycles  out  16  last measured period.
- periodValid  out  1  one-cycle pulse when periodCycles updates.
- stall  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset is synchronous and active-high on rst_in; single clock clk_in. Reset values:
  - state=IDLE, oscLoad=1, oscBc=0, oscK=K_MIN.
  - ack=err=periodValid=stall=running=0, periodCycles=0.
  - Latched config: k=K_MIN, amp=0.
  - Reset mid-operation aborts any load or measurement immediately.
- FSM states: IDLE, LOAD, RUN.
- IDLE:
  - oscLoad=1, oscBc=0 (oscillator held silent).
  - Accepts req when stop=0.
- LOAD:
  - oscLoad=1, oscBc={1'b0, latched amp}, oscK=latched k.
  - Lasts exactly LOAD_CYCLES cycles, then goes to RUN.
  - req is not acknowledged in LOAD.
- RUN:
  - oscLoad=0, running=1; oscK and oscBc hold their values.
  - Accepts req, which causes a retune.
- Request acceptance, in cycle T (IDLE or RUN, req=1, stop=0):
  - If reqK<K_MIN or reqAmp==0: err=1 in T+1, state unchanged, config unchanged.
  - Otherwise: latch k=reqK and amp=min(reqAmp, AMP_MAX); ack=1 in T+1; state=LOAD from T+1.
  - oscLoad is high for cycles T+1 .. T+LOAD_CYCLES.
  - ack and err are never high together. The requester drops req after the pulse; req still high in the cycle after ack counts as a new request.
- stop=1 has priority over req in every state. It forces IDLE next cycle with no ack or err; a pending req waits.
- Period meter, active only in RUN; cleared on entry to LOAD or IDLE:
  - Rising crossing: wave[11] was 1 in the previous sample and is 0 in the current one.
  - cnt increments every RUN cycle and saturates at TIMEOUT.
  - First crossing after a load: cnt<=1, no publish.
  - Each later crossing: periodCycles<=cnt, periodValid=1 the next cycle, cnt<=1.
  - The sign-history register is invalid on the first RUN cycle, so no crossing can be detected in that cycle.
- Watchdog: cnt==TIMEOUT in RUN → stall=1, reload using the same latched config (state LOAD).
- Arithmetic: all counters are unsigned; no wrap-around. Amplitude is zero-extended to 17 bits, and bit 16 of oscBc is always 0.

Decomposition:
- Package osc_seq_pkg contains:
  - state enum {IDLE, LOAD, RUN};
  - K_W=4, BC_W=17, WAVE_W=12, CNT_W=16 constants.
- Sub-module osc_period_meter contains the crossing detector, saturating counter, periodCycles/periodValid and the watchdog compare. Its ports are clk_in, rst_in, clear, en, wave, periodCycles, periodValid, timeout.
- The FSM and handshake stay in osc_sequencer.

Test Plan:
- Reset held for 3 cycles, then released with no req → oscLoad=1, oscBc=0, oscK=1, running=0; the outputs do not change.
- req with reqK=4, reqAmp=16'h4000 in IDLE at cycle T, with the real oscillator attached:
  - ack at T+1 only;
  - oscLoad high for T+1..T+2;
  - running from T+3;
  - periodValid pulses with periodCycles ∈ {25, 26} every time.
- req with reqK=0, then reqAmp=0 → err pulse each time, no ack, oscBc unchanged; reqAmp=16'hFFFF with k=4 → oscBc=17'h07FFF.
- In RUN, retune to k=8 → one LOAD of 2 cycles; the first measured period afterwards is in 100..101; no periodValid during LOAD.
- Drive wave with a constant 12'h100, TIMEOUT=16 → stall pulse after 16 RUN cycles, then oscLoad high for 2 cycles, repeating.
- stop and req high in the same RUN cycle → IDLE next cycle with no ack; release stop → ack one cycle later. Assert rst_in during LOAD → IDLE values on the next edge.
